// File: rtl/memory.sv
// Byte-addressed data memory: 16 interleaved 8-bit banks shared by a 32-bit system bus port
// and a 16-byte accelerator interface port, with absolute priority for the system bus.
module memory #(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          system_bus_en,
  input  logic          system_bus_rdwr,
  input  logic [3:0]    system_bus_mask,
  input  logic [31:0]   system_bus_wr_data,
  input  logic [AW-1:0] system_bus_addr,
  output logic [31:0]   system_bus_rd_data,
  input  logic          interface_en,
  input  logic          interface_rdwr,
  input  logic [4:0]    interface_control,
  input  logic [AW-1:0] interface_addr,
  input  logic [127:0]  din,
  output logic [127:0]  bank_dout
);

  localparam int RW = $clog2(DEPTH);

  logic          sys_rd;
  logic          intf_acc;
  logic          intf_rd;
  logic [4:0]    intf_n;
  logic [AW-1:0] base_addr;
  logic [3:0]    base_lo;
  logic [RW-1:0] base_row;
  logic [4:0]    lane_cnt;

  logic          bank_en  [16];
  logic          bank_we  [16];
  logic [RW-1:0] bank_row [16];
  logic [7:0]    bank_wd  [16];
  logic [127:0]  bank_q;

  logic          sys_rd_v;
  logic          intf_rd_v;
  logic [3:0]    rd_lo;
  logic [4:0]    intf_n_r;
  logic [31:0]   sys_hold;
  logic [127:0]  intf_hold;
  logic [127:0]  rot;
  logic [127:0]  intf_rot;

  // Only one port owns the banks in a cycle: the system bus whenever it is enabled.
  assign sys_rd    = system_bus_en & ~system_bus_rdwr;
  assign intf_acc  = ~system_bus_en & interface_en;
  assign intf_rd   = intf_acc & ~interface_rdwr;
  assign intf_n    = (interface_control > 5'd16) ? 5'd16 : interface_control;
  assign base_addr = system_bus_en ? system_bus_addr : interface_addr;
  assign base_lo   = base_addr[3:0];
  assign base_row  = base_addr[RW+3:4];
  assign lane_cnt  = system_bus_en ? 5'd4 : (intf_acc ? intf_n : 5'd0);

  always_comb begin
    logic [3:0] lane;
    logic       active;
    for (int k = 0; k < 16; k++) begin
      // Bank k serves lane (k - addr) mod 16; banks below the start bank sit on the next row.
      lane        = 4'(k) - base_lo;
      active      = {1'b0, lane} < lane_cnt;
      bank_en[k]  = active;
      bank_row[k] = base_row + RW'(4'(k) < base_lo);
      if (system_bus_en) begin
        bank_we[k] = active & system_bus_rdwr & system_bus_mask[lane[1:0]];
        bank_wd[k] = system_bus_wr_data[{lane[1:0], 3'b000} +: 8];
      end else begin
        bank_we[k] = active & interface_rdwr;
        bank_wd[k] = din[{lane, 3'b000} +: 8];
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_bank
    logic [7:0] ram [DEPTH];
    logic [7:0] q;
    // NOTE: the array and its read register have no reset so the bank maps onto plain SRAM/BRAM.
    always_ff @(posedge clk) begin
      if (bank_en[g]) begin
        if (bank_we[g]) ram[bank_row[g]] <= bank_wd[g];
        q <= ram[bank_row[g]];
      end
    end
    assign bank_q[g*8 +: 8] = q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_rd_v  <= 1'b0;
      intf_rd_v <= 1'b0;
      rd_lo     <= '0;
      intf_n_r  <= '0;
      sys_hold  <= '0;
      intf_hold <= '0;
    end else begin
      sys_rd_v  <= sys_rd;
      intf_rd_v <= intf_rd;
      if (sys_rd || intf_rd) rd_lo <= base_lo;
      if (intf_rd) intf_n_r <= intf_n;
      sys_hold  <= system_bus_rd_data;
      intf_hold <= bank_dout;
    end
  end

  // Rotate the bank read registers so lane 0 is the byte at the requested address.
  always_comb begin
    logic [3:0] idx;
    rot      = '0;
    intf_rot = '0;
    for (int i = 0; i < 16; i++) begin
      idx              = rd_lo + 4'(i);
      rot[i*8 +: 8]    = bank_q[{idx, 3'b000} +: 8];
      intf_rot[i*8 +: 8] = (5'(i) < intf_n_r) ? rot[i*8 +: 8] : 8'h00;
    end
  end

  // Fresh data is shown for the cycle after a read; otherwise the captured value is held.
  assign system_bus_rd_data = sys_rd_v  ? rot[31:0] : sys_hold;
  assign bank_dout          = intf_rd_v ? intf_rot  : intf_hold;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed cases plus random system-bus traffic against a
// byte-array model of the 4 KiB address space.
module tb_memory;

  logic         clk;
  logic         rst_n;
  logic         system_bus_en;
  logic         system_bus_rdwr;
  logic [3:0]   system_bus_mask;
  logic [31:0]  system_bus_wr_data;
  logic [31:0]  system_bus_addr;
  logic [31:0]  system_bus_rd_data;
  logic         interface_en;
  logic         interface_rdwr;
  logic [4:0]   interface_control;
  logic [31:0]  interface_addr;
  logic [127:0] din;
  logic [127:0] bank_dout;

  logic [7:0]   mem_m [4096];
  logic [31:0]  last_sys_exp;
  logic [127:0] last_intf_exp;
  int           n_checks;
  int           n_pass;

  memory #(.DEPTH(256), .AW(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .system_bus_en      (system_bus_en),
    .system_bus_rdwr    (system_bus_rdwr),
    .system_bus_mask    (system_bus_mask),
    .system_bus_wr_data (system_bus_wr_data),
    .system_bus_addr    (system_bus_addr),
    .system_bus_rd_data (system_bus_rd_data),
    .interface_en       (interface_en),
    .interface_rdwr     (interface_rdwr),
    .interface_control  (interface_control),
    .interface_addr     (interface_addr),
    .din                (din),
    .bank_dout          (bank_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] sys_exp(input int a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = mem_m[(a + i) % 4096];
    return r;
  endfunction

  function automatic logic [127:0] intf_exp(input int a, input int n);
    logic [127:0] r;
    int m;
    m = (n > 16) ? 16 : n;
    r = '0;
    for (int i = 0; i < m; i++) r[i*8 +: 8] = mem_m[(a + i) % 4096];
    return r;
  endfunction

  task automatic idle();
    system_bus_en     = 1'b0;
    system_bus_rdwr   = 1'b0;
    system_bus_mask   = 4'h0;
    interface_en      = 1'b0;
    interface_rdwr    = 1'b0;
    interface_control = 5'd0;
  endtask

  task automatic sys_wr(input int a, input logic [31:0] d, input logic [3:0] m);
    system_bus_en = 1'b1; system_bus_rdwr = 1'b1; system_bus_addr = a;
    system_bus_wr_data = d; system_bus_mask = m;
    for (int i = 0; i < 4; i++) if (m[i]) mem_m[(a + i) % 4096] = d[i*8 +: 8];
    @(posedge clk); #1; idle();
  endtask

  task automatic sys_rd(input string tag, input int a);
    system_bus_en = 1'b1; system_bus_rdwr = 1'b0; system_bus_addr = a;
    last_sys_exp = sys_exp(a);
    @(posedge clk); #1; idle();
    check(tag, 128'(system_bus_rd_data), 128'(last_sys_exp));
  endtask

  task automatic intf_wr(input int a, input int n, input logic [127:0] d);
    int m;
    interface_en = 1'b1; interface_rdwr = 1'b1; interface_addr = a;
    interface_control = 5'(n); din = d;
    m = (n > 16) ? 16 : n;
    for (int i = 0; i < m; i++) mem_m[(a + i) % 4096] = d[i*8 +: 8];
    @(posedge clk); #1; idle();
  endtask

  task automatic intf_rd(input string tag, input int a, input int n);
    interface_en = 1'b1; interface_rdwr = 1'b0; interface_addr = a;
    interface_control = 5'(n);
    last_intf_exp = intf_exp(a, n);
    @(posedge clk); #1; idle();
    check(tag, bank_dout, last_intf_exp);
  endtask

  initial begin
    logic [127:0] seq;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    system_bus_addr = '0; system_bus_wr_data = '0; interface_addr = '0; din = '0;
    idle();
    #12;
    check("reset_sys_out", 128'(system_bus_rd_data), 128'h0);
    check("reset_intf_out", bank_dout, 128'h0);
    @(negedge clk) rst_n = 1'b1;

    // Fill the whole array so every later read has a known reference.
    for (int r = 0; r < 256; r++)
      intf_wr(r * 16, 16, {$urandom, $urandom, $urandom, $urandom});

    sys_wr(32'h40, 32'hDEADBEEF, 4'b1111);
    sys_rd("aligned_word", 32'h40);
    check("aligned_const", 128'(system_bus_rd_data), 128'(32'hDEADBEEF));
    repeat (2) @(posedge clk);
    #1 check("sys_hold_idle", 128'(system_bus_rd_data), 128'(last_sys_exp));

    sys_wr(32'h40, 32'h11223344, 4'b0101);
    check("sys_hold_write", 128'(system_bus_rd_data), 128'(last_sys_exp));
    sys_rd("masked_word", 32'h40);
    check("masked_const", 128'(system_bus_rd_data), 128'(32'hDE22BE44));
    sys_wr(32'h40, 32'h00000000, 4'b0000);
    sys_rd("mask_zero_noop", 32'h40);

    sys_wr(32'h3E, 32'hA1B2C3D4, 4'b1111);
    sys_rd("unaligned_word", 32'h3E);
    check("unaligned_const", 128'(system_bus_rd_data), 128'(32'hA1B2C3D4));
    sys_rd("unaligned_upper", 32'h40);

    for (int i = 0; i < 16; i++) seq[i*8 +: 8] = 8'(i);
    intf_wr(32'h105, 16, seq);
    intf_rd("intf_wide16", 32'h105, 16);
    check("intf_wide_const", bank_dout, seq);
    intf_rd("intf_wide4", 32'h105, 4);
    check("intf_n4_const", bank_dout, 128'h03020100);
    intf_wr(32'h105, 0, {16{8'hFF}});
    intf_rd("intf_n0_noop", 32'h105, 16);
    intf_rd("intf_n20_clamp", 32'h105, 20);
    intf_rd("intf_odd_n", 32'h109, 7);

    intf_wr(32'hFF8, 16, {$urandom, $urandom, $urandom, $urandom});
    intf_rd("intf_wrap", 32'hFF8, 16);
    sys_rd("sys_wrap", 32'hFFE);

    // Simultaneous requests: the system bus wins, the interface write and read are dropped.
    intf_rd("prio_before", 32'h200, 16);
    system_bus_en = 1'b1; system_bus_rdwr = 1'b1; system_bus_addr = 32'h200;
    system_bus_wr_data = 32'hCAFEF00D; system_bus_mask = 4'hF;
    interface_en = 1'b1; interface_rdwr = 1'b1; interface_addr = 32'h200;
    interface_control = 5'd16; din = {16{8'hFF}};
    for (int i = 0; i < 4; i++) mem_m[32'h200 + i] = system_bus_wr_data[i*8 +: 8];
    @(posedge clk); #1; idle();
    sys_rd("prio_word", 32'h200);
    check("prio_const", 128'(system_bus_rd_data), 128'(32'hCAFEF00D));
    intf_rd("prio_row", 32'h200, 16);
    system_bus_en = 1'b1; system_bus_rdwr = 1'b0; system_bus_addr = 32'h40;
    interface_en = 1'b1; interface_rdwr = 1'b0; interface_addr = 32'h105; interface_control = 5'd16;
    @(posedge clk); #1; idle();
    check("prio_intf_hold", bank_dout, last_intf_exp);
    check("prio_sys_read", 128'(system_bus_rd_data), 128'(sys_exp(32'h40)));

    sys_rd("pre_reset_read", 32'h3E);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_sys", 128'(system_bus_rd_data), 128'h0);
    check("midrun_reset_intf", bank_dout, 128'h0);
    @(negedge clk) rst_n = 1'b1;
    sys_rd("post_reset_sys", 32'h3E);
    intf_rd("post_reset_intf", 32'h105, 16);

    for (int t = 0; t < 50; t++) begin
      int a;
      a = int'($urandom_range(1000, 0));
      sys_wr(a, $urandom, 4'($urandom));
      sys_rd("random_pair", a);
      if (t % 5 == 0) intf_rd("random_intf", a, int'($urandom_range(16, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
